calc_console: RTL and testbench
===============================

Name: calc_console

Overview:
- Parametrised front-panel controller for the FPGA calculator. Replaces the fixed 4-digit, 8-bit, 32-entry console.
- Debounces push-buttons and edits and stores instructions in an internal program memory.
- Drives an external ALU through a req/ack handshake and emits glyph codes to the downstream display driver.
- New relative to the previous generation: width/depth/digit count are generic, buttons produce one pulse per press, the operand cursor is nibble-selectable, and the ALU is a handshaked slave.

Parameters:
- N_DIGITS, 4, number of display digits (≥4)
- DATA_W, 8, signed operand width (two's complement, 4..16)
- ADDR_W, 5, program memory address width (depth 2**ADDR_W)
- SAMPLE_DIV, 5000, clk cycles between button samples (≥1)
- DEB_LEN, 8, consecutive high samples needed for a press (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode_read, mode_write, mode_exec  in  1 each  level mode selects; priority exec > read > write
- btn_inc, btn_dec, btn_next, btn_enter  in  1 each  raw push-buttons
- sign_neg  in  1  operand sign switch (1 = negative)
- alu_req  out  1  operation request
- alu_op  out  2  0 ADD, 1 SUB, 2 MUL, 3 DIV
- alu_a, alu_b  out  DATA_W  signed operands
- alu_ack  in  1  one-cycle result-valid
- alu_result  in  2*DATA_W  signed result
- alu_err  in  1  overflow or divide-by-zero, qualified by alu_ack
- glyph  out  5*N_DIGITS  digit i at [5i+4:5i], digit 0 rightmost
- state_o  out  4  current FSM state, for debug

Behaviour:
- Glyph codes: 0x00–0x0F hex digit; 0x10 blank; 0x11 minus; 0x12 'o' (overflow); 0x13 'A'; 0x14 'P'; 0x15 'E'.
- Reset (async):
  - state IDLE; alu_req 0; alu_op/alu_a/alu_b 0.
  - All glyphs blank; addr, cursor, edit registers 0.
  - Debounce shift registers and sample counter 0. Memory contents undefined.
- Debounce, per button:
  - A sample strobe fires every SAMPLE_DIV cycles, free-running in every state.
  - Each button's DEB_LEN-bit shift register shifts in on the strobe.
  - ev_* pulses for exactly one clk on the strobe where the register becomes all-ones from not-all-ones.
  - Holding a button gives one event. Release and re-press is required for the next event.
- Memory word: {op[1:0], b[DATA_W-1:0], a[DATA_W-1:0]}.
- Operand entry is sign-magnitude:
  - Magnitude register is DATA_W-1 bits, edited per nibble.
  - Number of nibbles NN = ceil((DATA_W-1)/4). The top nibble is masked to valid bits.
  - ev_inc / ev_dec adds or subtracts 1 on the cursor nibble, modulo that nibble's range, with no carry.
  - ev_next moves the cursor to (cursor+1) mod NN.
  - Stored value: magnitude if sign_neg=0, else two's-complement negation. A zero magnitude stores 0 whatever the sign.
- FSM transitions:
  - IDLE: glyph shows blank. Any mode high → ADDR, with addr kept from the last use.
  - ADDR: ev_inc/ev_dec change addr by ±1, wrapping modulo 2**ADDR_W. ev_enter goes by mode:
    - exec → EX_REQ
    - read → RD
    - write → WR_OP, with edit registers loaded from mem[addr]
  - WR_OP: ev_inc/ev_dec cycle op mod 4. ev_enter → WR_A with cursor 0.
  - WR_A: edit a; ev_enter → WR_B with cursor 0.
  - WR_B: edit b; ev_enter writes mem[addr] on that same clk and goes to ADDR. This is the only memory write.
  - RD: ev_next cycles the view op → a → b → op. Shows mem[addr]. ev_enter → ADDR.
  - EX_REQ: reads mem[addr], drives alu_op/a/b, asserts alu_req, goes to EX_WAIT next clk.
  - EX_WAIT: alu_req and operands are held stable until alu_ack. On the ack clk, alu_result/alu_err are captured, req drops, and the FSM goes to SHOW.
  - SHOW:
    - alu_err=1 → 'o' in digit 0, rest blank.
    - Otherwise digit N_DIGITS-1 is minus/blank for the sign, and the lower digits show |result| in hex.
    - If |result| needs more than N_DIGITS-1 digits → 'o'.
    - ev_enter → ADDR.
- Address display: digit N-1 = 'A', then addr in hex, right-aligned.
- Abort: all mode inputs low → IDLE on the next clk from any state, with no memory write. In EX_WAIT, alu_req drops immediately and a late ack is ignored.
- Mode change while not IDLE: the new priority mode takes effect only at the next ADDR ev_enter.
- Simultaneous button events: enter beats next, which beats inc, which beats dec. At most one action per clk.

Test Plan (bench uses SAMPLE_DIV=1, DEB_LEN=2):
- rst pulse mid-EX_WAIT (async, between clk edges) → alu_req=0 and state_o=IDLE immediately; all glyphs 0x10.
- btn_inc held high 50 cycles → exactly one ev_inc; in ADDR, addr goes 0→1. ev_dec at addr 0 → addr 31.
- Write at addr 3:
  - Sequence: op=SUB, a: mag 0x05 sign_neg=0; b: cursor nibble 1 set to 2, nibble 0 set to 3, sign_neg=1.
  - Required: mem[3] = {01, 8'hDD, 8'h05}. RD view b shows minus, 2, 3.
- Exec ADD of a=0x7F, b=0x01:
  - alu_req stays high 10 cycles until ack. result 0x0080, err 0 → glyphs [0x10,0x00,0x08,0x00] digit3..0.
  - alu_result=0xFFF6 → minus, 0x00, 0x00, 0x0A.
- Exec with alu_err=1 on ack → digit0=0x12 and the others 0x10. Dropping all modes in WR_B → IDLE, with mem unchanged.
- Same-clk ev_enter and ev_inc in WR_OP → transition to WR_A, op unchanged.

Source files
------------

// File: rtl/calc_console.sv
// ============================================================================
//  Module      : calc_console
//  Description : Calculator front panel: button debounce, program memory
//                editor, handshaked ALU sequencer and glyph generator.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module calc_console #(
    parameter int N_DIGITS   = 4,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int SAMPLE_DIV = 5000,
    parameter int DEB_LEN    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode_read,
    input  logic                    mode_write,
    input  logic                    mode_exec,
    input  logic                    btn_inc,
    input  logic                    btn_dec,
    input  logic                    btn_next,
    input  logic                    btn_enter,
    input  logic                    sign_neg,
    output logic                    alu_req,
    output logic [1:0]              alu_op,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    input  logic                    alu_ack,
    input  logic [2*DATA_W-1:0]     alu_result,
    input  logic                    alu_err,
    output logic [5*N_DIGITS-1:0]   glyph,
    output logic [3:0]              state_o
);

    localparam int c_NN     = (DATA_W + 2) / 4;
    localparam int c_TOP    = DATA_W - 1 - 4 * (c_NN - 1);
    localparam int c_CUR_W  = (c_NN > 1) ? $clog2(c_NN) : 1;
    localparam int c_PAD_W  = 4 * c_NN;
    localparam int c_CNT_W  = $clog2(SAMPLE_DIV + 1);
    localparam int c_MEM_W  = 2 + 2 * DATA_W;
    localparam int c_GW     = 5 * N_DIGITS;
    localparam int c_MAGW   = 4 * N_DIGITS + 2 * DATA_W;
    localparam int c_ADIG   = (ADDR_W + 3) / 4;
    localparam int c_APAD_W = 4 * c_ADIG;

    localparam logic [4:0] c_G_BLANK = 5'h10;
    localparam logic [4:0] c_G_MINUS = 5'h11;
    localparam logic [4:0] c_G_OVF   = 5'h12;
    localparam logic [4:0] c_G_A     = 5'h13;
    localparam logic [4:0] c_G_P     = 5'h14;

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_ADDR    = 4'd1;
    localparam logic [3:0] c_WR_OP   = 4'd2;
    localparam logic [3:0] c_WR_A    = 4'd3;
    localparam logic [3:0] c_WR_B    = 4'd4;
    localparam logic [3:0] c_RD      = 4'd5;
    localparam logic [3:0] c_EX_REQ  = 4'd6;
    localparam logic [3:0] c_EX_WAIT = 4'd7;
    localparam logic [3:0] c_SHOW    = 4'd8;

    logic [3:0]               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]       r_smp_cnt;
    logic                     w_strobe;
    logic [3:0]               w_btn, w_ev;
    logic                     w_act_enter, w_act_next, w_act_inc, w_act_dec;
    logic                     w_any_mode;
    logic [ADDR_W-1:0]        r_addr;
    logic [1:0]               r_op;
    logic [DATA_W-1:0]        r_a, r_b;
    logic [DATA_W-2:0]        r_mag, w_mag_next;
    logic [c_CUR_W-1:0]       r_cursor, w_cursor_next;
    logic [1:0]               r_view;
    logic [2*DATA_W-1:0]      r_res, w_res_abs;
    logic                     r_err;
    logic [c_MEM_W-1:0]       r_mem [2**ADDR_W];
    logic [c_MEM_W-1:0]       w_word;
    logic [1:0]               w_mem_op;
    logic [DATA_W-1:0]        w_mem_a, w_mem_b, w_a_abs, w_b_abs, w_enc;
    logic                     w_mem_we;
    logic [c_PAD_W-1:0]       w_pad;
    logic [3:0]               w_nib, w_mask;
    logic [c_APAD_W-1:0]      w_addr_pad;

    function automatic logic [DATA_W-1:0] f_enc(input logic [DATA_W-2:0] mag, input logic neg);
        logic [DATA_W-1:0] ext;
        ext = {1'b0, mag};
        return neg ? -ext : ext;
    endfunction

    function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    // Sign in the leftmost digit, zero-padded hex magnitude below it.
    function automatic logic [c_GW-1:0] f_num(input logic neg, input logic [c_MAGW-1:0] mag);
        logic [c_GW-1:0] g;
        g = {N_DIGITS{c_G_BLANK}};
        if (|(mag >> (4 * (N_DIGITS - 1)))) begin
            g[4:0] = c_G_OVF;
        end else begin
            for (int k = 0; k < N_DIGITS - 1; k++) g[5*k +: 5] = {1'b0, mag[4*k +: 4]};
            g[5*(N_DIGITS-1) +: 5] = (neg && mag != '0) ? c_G_MINUS : c_G_BLANK;
        end
        return g;
    endfunction

    // ------------------------------------------------------------ debounce
    assign w_strobe = (r_smp_cnt == c_CNT_W'(SAMPLE_DIV - 1));
    assign w_btn    = {btn_enter, btn_next, btn_dec, btn_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_smp_cnt <= '0;
        else if (w_strobe) r_smp_cnt <= '0;
        else               r_smp_cnt <= r_smp_cnt + c_CNT_W'(1);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
        logic [DEB_LEN-1:0] r_sh;
        logic [DEB_LEN-1:0] w_sh_new;
        logic               r_ev;
        assign w_sh_new = {r_sh[DEB_LEN-2:0], w_btn[gi]};
        assign w_ev[gi] = r_ev;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sh <= '0;
                r_ev <= 1'b0;
            end else begin
                r_ev <= w_strobe & (&w_sh_new) & ~(&r_sh);
                if (w_strobe) r_sh <= w_sh_new;
            end
        end
    end

    assign w_act_enter = w_ev[3];
    assign w_act_next  = w_ev[2] & ~w_ev[3];
    assign w_act_inc   = w_ev[0] & ~w_ev[3] & ~w_ev[2];
    assign w_act_dec   = w_ev[1] & ~w_ev[3] & ~w_ev[2] & ~w_ev[0];
    assign w_any_mode  = mode_exec | mode_read | mode_write;

    // -------------------------------------------------------------- memory
    assign w_word   = r_mem[r_addr];
    assign w_mem_op = w_word[c_MEM_W-1 -: 2];
    assign w_mem_b  = w_word[2*DATA_W-1:DATA_W];
    assign w_mem_a  = w_word[DATA_W-1:0];
    assign w_a_abs  = f_abs(w_mem_a);
    assign w_b_abs  = f_abs(w_mem_b);
    assign w_enc    = f_enc(r_mag, sign_neg);
    assign w_mem_we = w_any_mode && (r_state == c_WR_B) && w_act_enter;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_addr] <= {r_op, w_enc, r_a};
    end

    // Per-nibble edit without carry; top nibble wraps within its valid bits.
    always_comb begin
        w_pad  = c_PAD_W'(r_mag);
        w_nib  = 4'd0;
        w_mask = 4'hF;
        for (int k = 0; k < c_NN; k++) begin
            if (r_cursor == c_CUR_W'(k)) begin
                w_mask = (k == c_NN - 1) ? 4'((1 << c_TOP) - 1) : 4'hF;
                w_nib  = w_pad[4*k +: 4];
                w_nib  = (w_act_inc ? w_nib + 4'd1 : w_nib - 4'd1) & w_mask;
                w_pad[4*k +: 4] = w_nib;
            end
        end
        w_mag_next = w_pad[DATA_W-2:0];
    end

    assign w_cursor_next = (r_cursor == c_CUR_W'(c_NN - 1)) ? '0 : r_cursor + c_CUR_W'(1);

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mag    <= '0;
            r_cursor <= '0;
            r_view   <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else if (w_any_mode) begin
            case (r_state)
                c_ADDR: begin
                    if (w_act_enter) begin
                        r_view <= 2'd0;
                        if (!mode_exec && !mode_read) begin
                            r_op <= w_mem_op;
                            r_a  <= w_mem_a;
                            r_b  <= w_mem_b;
                        end
                    end else if (w_act_inc) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end else if (w_act_dec) begin
                        r_addr <= r_addr - ADDR_W'(1);
                    end
                end
                c_WR_OP: begin
                    if (w_act_enter) begin
                        r_cursor <= '0;
                        r_mag    <= w_a_abs_edit(r_a);
                    end else if (w_act_inc) begin
                        r_op <= r_op + 2'd1;
                    end else if (w_act_dec) begin
                        r_op <= r_op - 2'd1;
                    end
                end
                c_WR_A, c_WR_B: begin
                    if (w_act_enter) begin
                        r_cursor <= '0;
                        if (r_state == c_WR_A) begin
                            r_a   <= w_enc;
                            r_mag <= w_a_abs_edit(r_b);
                        end
                    end else if (w_act_next) begin
                        r_cursor <= w_cursor_next;
                    end else if (w_act_inc || w_act_dec) begin
                        r_mag <= w_mag_next;
                    end
                end
                c_RD: begin
                    if (w_act_next) r_view <= (r_view == 2'd2) ? 2'd0 : r_view + 2'd1;
                end
                c_EX_REQ: begin
                    alu_op <= w_mem_op;
                    alu_a  <= w_mem_a;
                    alu_b  <= w_mem_b;
                end
                c_EX_WAIT: begin
                    if (alu_ack) begin
                        r_res <= alu_result;
                        r_err <= alu_err;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic [DATA_W-2:0] w_a_abs_edit(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] m;
        m = f_abs(v);
        return m[DATA_W-2:0];
    endfunction

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_any_mode) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:    w_state_nxt = c_ADDR;
                c_ADDR:    if (w_act_enter) w_state_nxt = mode_exec ? c_EX_REQ :
                                                          mode_read ? c_RD : c_WR_OP;
                c_WR_OP:   if (w_act_enter) w_state_nxt = c_WR_A;
                c_WR_A:    if (w_act_enter) w_state_nxt = c_WR_B;
                c_WR_B:    if (w_act_enter) w_state_nxt = c_ADDR;
                c_RD:      if (w_act_enter) w_state_nxt = c_ADDR;
                c_EX_REQ:  w_state_nxt = c_EX_WAIT;
                c_EX_WAIT: if (alu_ack) w_state_nxt = c_SHOW;
                c_SHOW:    if (w_act_enter) w_state_nxt = c_ADDR;
                default:   w_state_nxt = c_IDLE;
            endcase
        end
    end

    assign w_res_abs  = r_res[2*DATA_W-1] ? -r_res : r_res;
    assign w_addr_pad = c_APAD_W'(r_addr);

    always_comb begin
        glyph   = {N_DIGITS{c_G_BLANK}};
        alu_req = (r_state == c_EX_WAIT) && w_any_mode;
        state_o = r_state;
        case (r_state)
            c_ADDR: begin
                glyph[5*(N_DIGITS-1) +: 5] = c_G_A;
                for (int k = 0; k < c_ADIG; k++) glyph[5*k +: 5] = {1'b0, w_addr_pad[4*k +: 4]};
            end
            c_WR_OP: begin
                glyph[5*(N_DIGITS-1) +: 5] = c_G_P;
                glyph[4:0] = {3'b000, r_op};
            end
            c_WR_A, c_WR_B: glyph = f_num(sign_neg, c_MAGW'(r_mag));
            c_RD: begin
                case (r_view)
                    2'd1:    glyph = f_num(w_mem_a[DATA_W-1], c_MAGW'(w_a_abs));
                    2'd2:    glyph = f_num(w_mem_b[DATA_W-1], c_MAGW'(w_b_abs));
                    default: begin
                        glyph[5*(N_DIGITS-1) +: 5] = c_G_P;
                        glyph[4:0] = {3'b000, w_mem_op};
                    end
                endcase
            end
            c_SHOW: begin
                if (r_err) glyph[4:0] = c_G_OVF;
                else       glyph = f_num(r_res[2*DATA_W-1], c_MAGW'(w_res_abs));
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_calc_console.sv
// ============================================================================
//  Module      : tb_calc_console
//  Description : Scoreboard bench for calc_console (fast debounce settings).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_console;

    localparam int LAT = 10;
    localparam logic [3:0] c_IDLE = 4'd0, c_ADDR = 4'd1, c_WR_OP = 4'd2, c_WR_A = 4'd3,
                           c_WR_B = 4'd4, c_RD = 4'd5, c_EX_WAIT = 4'd7, c_SHOW = 4'd8;
    localparam logic [4:0] B = 5'h10, M = 5'h11, O = 5'h12, A = 5'h13, P = 5'h14;

    logic        clk = 1'b0, rst;
    logic        mode_read, mode_write, mode_exec;
    logic        btn_inc, btn_dec, btn_next, btn_enter, sign_neg;
    logic        alu_req, alu_ack, alu_err;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_result;
    logic [19:0] glyph;
    logic [3:0]  state_o;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
        bit          noack;
    } alu_txn_t;

    alu_txn_t    txq[$];
    logic [19:0] gq[$];
    int          n_vec = 0, n_err = 0;

    calc_console #(.N_DIGITS(4), .DATA_W(8), .ADDR_W(5), .SAMPLE_DIV(1), .DEB_LEN(2)) dut (
        .clk(clk), .rst(rst),
        .mode_read(mode_read), .mode_write(mode_write), .mode_exec(mode_exec),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next), .btn_enter(btn_enter),
        .sign_neg(sign_neg),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ack(alu_ack), .alu_result(alu_result), .alu_err(alu_err),
        .glyph(glyph), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] g4(input logic [4:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    // 0 inc, 1 dec, 2 next, 3 enter, 4 enter+inc together
    task automatic press(input int b);
        case (b)
            0: btn_inc = 1'b1;
            1: btn_dec = 1'b1;
            2: btn_next = 1'b1;
            3: btn_enter = 1'b1;
            default: begin btn_enter = 1'b1; btn_inc = 1'b1; end
        endcase
        repeat (4) @(negedge clk);
        {btn_inc, btn_dec, btn_next, btn_enter} = 4'b0;
        repeat (4) @(negedge clk);
    endtask

    // Steer the displayed nibble at digit d to target (initial memory is undefined).
    task automatic set_nibble(input int d, input int target, input int modulus);
        int cur, n;
        cur = int'(glyph[5*d +: 4]);
        n = (target - cur + modulus) % modulus;
        for (int i = 0; i < n; i++) press(0);
    endtask

    task automatic wait_state(input logic [3:0] s, input int bound, input string tag);
        int n = 0;
        while (state_o !== s && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, state_o, s);
    endtask

    task automatic run_exec(input logic [15:0] res, input logic err, input logic [19:0] exp_g);
        txq.push_back('{op: 2'd0, a: 8'h7F, b: 8'h01, res: res, err: err, noack: 1'b0});
        gq.push_back(exp_g);
        press(3);
        wait_state(c_SHOW, 100, "show_wait");
        check("show_glyph", glyph, gq.pop_front());
        press(3);
        check("show_to_addr", state_o, c_ADDR);
    endtask

    // ALU slave model: checks operands, holds off LAT cycles, then acks.
    initial begin
        alu_txn_t t;
        alu_ack = 1'b0; alu_result = '0; alu_err = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_req && txq.size() > 0) begin
                t = txq.pop_front();
                check("alu_op", alu_op, t.op);
                check("alu_a", alu_a, t.a);
                check("alu_b", alu_b, t.b);
                if (t.noack) begin
                    for (int k = 0; k < 200; k++) begin
                        if (!alu_req) break;
                        @(negedge clk);
                    end
                end else begin
                    for (int k = 0; k < LAT - 1; k++) begin
                        @(negedge clk);
                        check("req_hold", alu_req, 1);
                        check("a_hold", alu_a, t.a);
                    end
                    alu_result = t.res; alu_err = t.err; alu_ack = 1'b1;
                    @(negedge clk);
                    alu_ack = 1'b0;
                    check("req_drop", alu_req, 0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        {mode_read, mode_write, mode_exec} = 3'b0;
        {btn_inc, btn_dec, btn_next, btn_enter, sign_neg} = 5'b0;
        repeat (3) @(negedge clk);
        check("rst_state", state_o, c_IDLE);
        check("rst_glyph", glyph, g4(B, B, B, B));
        check("rst_req", alu_req, 0);
        check("rst_alu_a", alu_a, 0);
        rst = 1'b0;
        @(negedge clk);

        // address navigation and debounce
        mode_write = 1'b1;
        @(negedge clk);
        check("idle_to_addr", state_o, c_ADDR);
        check("addr0", glyph, g4(A, B, 5'h00, 5'h00));
        btn_inc = 1'b1;
        repeat (50) @(negedge clk);
        btn_inc = 1'b0;
        repeat (4) @(negedge clk);
        check("addr_hold_once", glyph, g4(A, B, 5'h00, 5'h01));
        press(1);
        press(1);
        check("addr_wrap", glyph, g4(A, B, 5'h01, 5'h0F));
        for (int i = 0; i < 4; i++) press(0);
        check("addr3", glyph, g4(A, B, 5'h00, 5'h03));

        // write mem[3] = {SUB, -0x23, +0x05}
        press(3);
        check("enter_wr_op", state_o, c_WR_OP);
        set_nibble(0, 1, 4);
        press(3);
        sign_neg = 1'b0;
        set_nibble(0, 5, 16);
        press(2);
        set_nibble(1, 0, 8);
        press(3);
        check("enter_wr_b", state_o, c_WR_B);
        sign_neg = 1'b1;
        press(2);
        set_nibble(1, 2, 8);
        press(2);
        set_nibble(0, 3, 16);
        press(3);
        check("wr_done", state_o, c_ADDR);

        // read it back
        mode_read = 1'b1;
        press(3);
        check("enter_rd", state_o, c_RD);
        check("rd_op", glyph, g4(P, B, B, 5'h01));
        press(2);
        check("rd_a", glyph, g4(B, 5'h00, 5'h00, 5'h05));
        press(2);
        check("rd_b", glyph, g4(M, 5'h00, 5'h02, 5'h03));
        press(3);
        mode_read = 1'b0;

        // write mem[5] = {ADD, 0x01, 0x7F}
        sign_neg = 1'b0;
        press(0);
        press(0);
        check("addr5", glyph, g4(A, B, 5'h00, 5'h05));
        press(3);
        set_nibble(0, 0, 4);
        press(3);
        set_nibble(0, 15, 16);
        press(2);
        set_nibble(1, 7, 8);
        press(3);
        set_nibble(0, 1, 16);
        press(2);
        set_nibble(1, 0, 8);
        press(3);

        // executions
        mode_exec = 1'b1;
        run_exec(16'h0080, 1'b0, g4(B, 5'h00, 5'h08, 5'h00));
        run_exec(16'hFFF6, 1'b0, g4(M, 5'h00, 5'h00, 5'h0A));
        run_exec(16'h0000, 1'b1, g4(B, B, B, O));
        run_exec(16'h1000, 1'b0, g4(B, B, B, O));
        mode_exec = 1'b0;

        // enter beats inc, then abort in WR_B
        press(1);
        press(1);
        press(3);
        check("abort_wr_op", state_o, c_WR_OP);
        press(4);
        check("enter_over_inc", state_o, c_WR_A);
        press(3);
        check("abort_in_wr_b", state_o, c_WR_B);
        sign_neg = 1'b1;
        press(0);
        press(0);
        mode_write = 1'b0;
        @(negedge clk);
        check("abort_state", state_o, c_IDLE);
        check("abort_glyph", glyph, g4(B, B, B, B));
        mode_read = 1'b1;
        @(negedge clk);
        press(3);
        check("post_abort_op", glyph, g4(P, B, B, 5'h01));
        press(2);
        check("post_abort_a", glyph, g4(B, 5'h00, 5'h00, 5'h05));
        press(2);
        check("post_abort_b", glyph, g4(M, 5'h00, 5'h02, 5'h03));
        press(3);

        // async reset while waiting on the ALU
        mode_exec = 1'b1;
        txq.push_back('{op: 2'd1, a: 8'h05, b: 8'hDD, res: 16'h0, err: 1'b0, noack: 1'b1});
        press(3);
        wait_state(c_EX_WAIT, 50, "ex_wait");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", alu_req, 0);
        check("mid_rst_state", state_o, c_IDLE);
        check("mid_rst_glyph", glyph, g4(B, B, B, B));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_addr", glyph, g4(A, B, 5'h00, 5'h00));
        check("queue_empty", txq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
